// File: rtl/debounce_bank.sv
// debounce_bank: per-channel 2-FF synchroniser, exact-count debounce filter,
// rise/fall pulses and long-press detection with optional auto-repeat.
module debounce_bank #(
    parameter int CHANNELS      = 4,
    parameter int DB_CYCLES     = 2048,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] db_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] hold,
    output logic                any_event
);

    localparam int HMAX      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW        = $clog2(DB_CYCLES);
    localparam int HW        = $clog2(HMAX + 1);
    localparam bit REPEAT_EN = (REPEAT_CYCLES > 0);

    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_EN ? (REPEAT_CYCLES - 1) : 0);
    localparam logic [CHANNELS-1:0] POL = {CHANNELS{ACTIVE_LOW}};

    logic [CHANNELS-1:0]         s1_q,   s1_d;
    logic [CHANNELS-1:0]         s_q,    s_d;
    logic [CHANNELS-1:0]         db_q,   db_d;
    logic [CHANNELS-1:0]         rise_q, rise_d;
    logic [CHANNELS-1:0]         fall_q, fall_d;
    logic [CHANNELS-1:0]         hold_q, hold_d;
    logic [CHANNELS-1:0]         rep_q,  rep_d;
    logic [CHANNELS-1:0][CW-1:0] cnt_q,  cnt_d;
    logic [CHANNELS-1:0][HW-1:0] hcnt_q, hcnt_d;
    logic                        any_q,  any_d;

    always_comb begin
        s1_d   = button_in ^ POL;
        s_d    = s1_q;
        db_d   = db_q;
        cnt_d  = cnt_q;
        hcnt_d = hcnt_q;
        rep_d  = rep_q;
        rise_d = '0;
        fall_d = '0;
        hold_d = '0;

        for (int c = 0; c < CHANNELS; c++) begin
            if (s_q[c] == db_q[c]) begin
                cnt_d[c] = '0;
            end else if (cnt_q[c] == DB_LAST) begin
                db_d[c]   = s_q[c];
                cnt_d[c]  = '0;
                rise_d[c] = s_q[c];
                fall_d[c] = ~s_q[c];
            end else begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end

            // rep_q marks that the first long-press pulse has already fired;
            // without repeat the counter simply freezes afterwards.
            if (!db_q[c] || fall_d[c]) begin
                hcnt_d[c] = '0;
                rep_d[c]  = 1'b0;
            end else if (REPEAT_EN || !rep_q[c]) begin
                if (hcnt_q[c] == (rep_q[c] ? REP_LAST : HOLD_LAST)) begin
                    hold_d[c] = 1'b1;
                    hcnt_d[c] = '0;
                    rep_d[c]  = 1'b1;
                end else begin
                    hcnt_d[c] = hcnt_q[c] + 1'b1;
                end
            end
        end

        any_d = |{rise_d, fall_d, hold_d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= '0;
            s_q    <= '0;
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            hold_q <= '0;
            rep_q  <= '0;
            cnt_q  <= '0;
            hcnt_q <= '0;
            any_q  <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s_q    <= s_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            hold_q <= hold_d;
            rep_q  <= rep_d;
            cnt_q  <= cnt_d;
            hcnt_q <= hcnt_d;
            any_q  <= any_d;
        end
    end

    assign db_out    = db_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign hold      = hold_q;
    assign any_event = any_q;

endmodule
